// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM state encoding and pipeline write/flush bundle layout
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2} state_t;
  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_t;
  localparam ctrl_t CTRL_INIT   = 9'b000101011;
  localparam ctrl_t CTRL_RUN    = 9'b101010100;
  localparam ctrl_t CTRL_FREEZE = 9'b000000001;
  localparam ctrl_t CTRL_TAKEN  = 9'b111111110;
  localparam ctrl_t CTRL_LU     = 9'b000011100;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with memory-wait FSM and perf counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memtoreg,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             exmem_memtoreg,
  input  logic             exmem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             timeout_err
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t state, next;
  ctrl_t ctrl;
  logic [WW-1:0] wait_cnt;
  logic mem_stall, taken, lu, active, timeout_hit;
  assign mem_stall   = (exmem_memtoreg | exmem_memwrite) & ~dmem_ready;
  assign taken       = exmem_branch & exmem_zero;
  assign lu          = idex_memtoreg & (idex_rd != 5'd0) & ((idex_rd == id_rs1) | (idex_rd == id_rs2));
  assign active      = (state == RUN) || (state == MEM_WAIT);
  assign timeout_hit = (state == MEM_WAIT) && mem_stall && (wait_cnt == WW'(MEM_TIMEOUT - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= INIT;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= next;
      wait_cnt <= (state == MEM_WAIT) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  always_comb begin
    next = INIT;
    case (state)
      INIT:     next = RUN;
      RUN:      next = mem_stall ? MEM_WAIT : RUN;
      MEM_WAIT: next = (mem_stall && !timeout_hit) ? MEM_WAIT : RUN;
      default:  next = INIT;
    endcase
  end
  always_comb
    ctrl = !active  ? CTRL_INIT :
           mem_stall ? CTRL_FREEZE :
           taken     ? CTRL_TAKEN :
           lu        ? CTRL_LU : CTRL_RUN;
  assign pc_write    = ctrl.pc_write;
  assign pc_src      = ctrl.pc_src;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_write  = ctrl.idex_write;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_write = ctrl.exmem_write;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign state_o     = state;
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(active && !ctrl.pc_write), .count(stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .reset(reset), .inc(active && ctrl.pc_src), .count(flush_count)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with a queued scoreboard checked at the falling edge
module tb_hazard_ctrl;
  localparam logic [8:0] C_INIT = 9'b000101011;
  localparam logic [8:0] C_RUN  = 9'b101010100;
  localparam logic [8:0] C_FRZ  = 9'b000000001;
  localparam logic [8:0] C_TKN  = 9'b111111110;
  localparam logic [8:0] C_LU   = 9'b000011100;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic idex_memtoreg, exmem_branch, exmem_zero, exmem_memtoreg, exmem_memwrite, dmem_ready;
  logic pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush, memwb_flush;
  logic [1:0] state_o;
  logic [15:0] stall_count, flush_count;
  logic timeout_err;
  logic pc_write2, pc_src2, ifid_write2, ifid_flush2, idex_write2, idex_flush2, exmem_write2, exmem_flush2, memwb_flush2;
  logic [1:0] state_o2;
  logic [1:0] stall_count2, flush_count2;
  logic timeout_err2;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_rd(idex_rd),
    .idex_memtoreg(idex_memtoreg), .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_memtoreg(exmem_memtoreg), .exmem_memwrite(exmem_memwrite), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .state_o(state_o),
    .stall_count(stall_count), .flush_count(flush_count), .timeout_err(timeout_err)
  );

  hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_rd(idex_rd),
    .idex_memtoreg(idex_memtoreg), .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_memtoreg(exmem_memtoreg), .exmem_memwrite(exmem_memwrite), .dmem_ready(dmem_ready),
    .pc_write(pc_write2), .pc_src(pc_src2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
    .idex_write(idex_write2), .idex_flush(idex_flush2), .exmem_write(exmem_write2),
    .exmem_flush(exmem_flush2), .memwb_flush(memwb_flush2), .state_o(state_o2),
    .stall_count(stall_count2), .flush_count(flush_count2), .timeout_err(timeout_err2)
  );

  wire [8:0] ctrl = {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
                     exmem_write, exmem_flush, memwb_flush};

  typedef struct {
    string       nm;
    logic [1:0]  st;
    logic [8:0]  c;
    int          sc;
    int          fc;
    logic        te;
    int          sc2;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input string f, input longint act, input longint want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", nm, f, act, want);
    end
  endtask

  always @(negedge clk)
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, "state_o", longint'(state_o), longint'(e.st));
      chk(e.nm, "ctrl", longint'(ctrl), longint'(e.c));
      chk(e.nm, "stall_count", longint'(stall_count), longint'(e.sc));
      chk(e.nm, "flush_count", longint'(flush_count), longint'(e.fc));
      chk(e.nm, "timeout_err", longint'(timeout_err), longint'(e.te));
      chk(e.nm, "stall_count_w2", longint'(stall_count2), longint'(e.sc2));
    end

  task automatic step(input string nm, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic lm, input logic br, input logic z,
                      input logic mr, input logic mw, input logic rdy,
                      input logic [1:0] st, input logic [8:0] c, input int sc, input int fc,
                      input logic te, input int sc2);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; id_rs1 = rs1; id_rs2 = rs2; idex_rd = rd; idex_memtoreg = lm;
    exmem_branch = br; exmem_zero = z; exmem_memtoreg = mr; exmem_memwrite = mw; dmem_ready = rdy;
    e = '{nm, st, c, sc, fc, te, sc2};
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b0; id_rs1 = '0; id_rs2 = '0; idex_rd = '0; idex_memtoreg = 1'b0;
    exmem_branch = 1'b0; exmem_zero = 1'b0; exmem_memtoreg = 1'b0; exmem_memwrite = 1'b0;
    dmem_ready = 1'b1;
    #2 reset = 1'b1;
    //    name          r  rs1 rs2 rd lm br z mr mw rdy  st ctrl    sc  fc te sc2
    step("rst_hold",    1, 0,  0,  0, 0, 0, 0, 0, 0, 1,  0, C_INIT, 0,  0, 0, 0);
    step("init_once",   0, 0,  0,  0, 0, 0, 0, 0, 0, 1,  0, C_INIT, 0,  0, 0, 0);
    step("run",         0, 0,  0,  0, 0, 0, 0, 0, 0, 1,  1, C_RUN,  0,  0, 0, 0);
    step("lu",          0, 3,  5,  5, 1, 0, 0, 0, 0, 1,  1, C_LU,   0,  0, 0, 0);
    step("lu_rd0",      0, 0,  0,  0, 1, 0, 0, 0, 0, 1,  1, C_RUN,  1,  0, 0, 1);
    step("taken",       0, 0,  0,  0, 0, 1, 1, 0, 0, 1,  1, C_TKN,  1,  0, 0, 1);
    step("not_taken",   0, 0,  0,  0, 0, 1, 0, 0, 0, 1,  1, C_RUN,  1,  1, 0, 1);
    step("ld_miss1",    0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  1, C_FRZ,  1,  1, 0, 1);
    step("ld_miss2",    0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  2, C_FRZ,  2,  1, 0, 2);
    step("ld_miss3",    0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  2, C_FRZ,  3,  1, 0, 3);
    step("ld_ready",    0, 0,  0,  0, 0, 0, 0, 1, 0, 1,  2, C_RUN,  4,  1, 0, 3);
    step("idle1",       0, 0,  0,  0, 0, 0, 0, 0, 0, 1,  1, C_RUN,  4,  1, 0, 3);
    step("st_miss0",    0, 0,  0,  0, 0, 0, 0, 0, 1, 0,  1, C_FRZ,  4,  1, 0, 3);
    step("st_wait1",    0, 0,  0,  0, 0, 0, 0, 0, 1, 0,  2, C_FRZ,  5,  1, 0, 3);
    step("st_wait2",    0, 0,  0,  0, 0, 0, 0, 0, 1, 0,  2, C_FRZ,  6,  1, 0, 3);
    step("st_wait3",    0, 0,  0,  0, 0, 0, 0, 0, 1, 0,  2, C_FRZ,  7,  1, 0, 3);
    step("st_wait4",    0, 0,  0,  0, 0, 0, 0, 0, 1, 0,  2, C_FRZ,  8,  1, 0, 3);
    step("after_to",    0, 0,  0,  0, 0, 0, 0, 0, 0, 1,  1, C_RUN,  9,  1, 1, 3);
    step("all3_miss",   0, 7,  0,  7, 1, 1, 1, 1, 0, 0,  1, C_FRZ,  9,  1, 1, 3);
    step("all3_ready",  0, 7,  0,  7, 1, 1, 1, 1, 0, 1,  2, C_TKN, 10,  1, 1, 3);
    step("idle2",       0, 0,  0,  0, 0, 0, 0, 0, 0, 1,  1, C_RUN, 10,  2, 1, 3);
    step("st_miss_r",   0, 0,  0,  0, 0, 0, 0, 0, 1, 0,  1, C_FRZ, 10,  2, 1, 3);
    step("st_wait_r",   0, 0,  0,  0, 0, 0, 0, 0, 1, 0,  2, C_FRZ, 11,  2, 1, 3);
    step("rst_mid",     1, 0,  0,  0, 0, 0, 0, 0, 1, 0,  0, C_INIT, 0,  0, 0, 0);
    step("init_after",  0, 0,  0,  0, 0, 0, 0, 0, 0, 1,  0, C_INIT, 0,  0, 0, 0);
    step("run_after",   0, 0,  0,  0, 0, 0, 0, 0, 0, 1,  1, C_RUN,  0,  0, 0, 0);
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of stall and flush performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before the timeout error is raised.
REQ-003 SHALL have ports: clk in 1, rising-edge clock. reset in 1, asynchronous active-high reset.
REQ-004 SHALL have ports: id_rs1 in 5, ID source reg 1. id_rs2 in 5, ID source reg 2. idex_rd in 5, EX dest. idex_memtoreg in 1, EX instruction is a load.
REQ-005 SHALL have ports: exmem_branch in 1, MEM-stage branch. exmem_zero in 1, MEM-stage branch condition. exmem_memtoreg in 1, MEM load. exmem_memwrite in 1, MEM store. dmem_ready in 1, data memory access completes this cycle.
REQ-006 SHALL have outputs (1 bit each): pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush, memwb_flush.
REQ-007 SHALL have outputs: state_o out 2, FSM state. stall_count out CNT_W. flush_count out CNT_W. timeout_err out 1, sticky.

Function
REQ-008 SHALL implement the FSM states INIT=0, RUN=1, MEM_WAIT=2; code 3 is illegal and SHALL go to INIT on the next edge.
REQ-009 In INIT, SHALL assert all *_flush, deassert pc_write, pc_src and all *_write, and go to RUN on the next edge.
REQ-010 Defaults in RUN: pc_write=1, all *_write=1, all *_flush=0, pc_src=0.
REQ-011 Memory stall condition: mem_stall = (exmem_memtoreg | exmem_memwrite) & ~dmem_ready.
REQ-012 Branch-taken condition: taken = exmem_branch & exmem_zero.
REQ-013 Load-use condition: lu = idex_memtoreg & (idex_rd != 0) & ((idex_rd == id_rs1) | (idex_rd == id_rs2)).
REQ-014 Priority SHALL be mem_stall > taken > lu, evaluated combinationally in the same cycle.
REQ-015 On mem_stall in RUN or MEM_WAIT: pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, memwb_flush=1, all other flushes 0; in RUN, next state is MEM_WAIT.
REQ-016 On taken (no mem_stall): pc_src=1, pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
REQ-017 On lu (no mem_stall, no taken): pc_write=0, ifid_write=0, idex_flush=1, for exactly one bubble per hazard occurrence.
REQ-018 In MEM_WAIT with dmem_ready=1: outputs are the RUN evaluation of taken/lu, and next state is RUN.
REQ-019 A MEM_WAIT cycle counter SHALL clear on entry and increment per MEM_WAIT cycle; when it reaches MEM_TIMEOUT, SHALL set timeout_err and force the next state to RUN; timeout_err clears only on reset.
REQ-020 stall_count SHALL increment in each cycle where pc_write=0 outside INIT, and SHALL saturate at all-ones.
REQ-021 flush_count SHALL increment in each taken-redirect cycle, and SHALL saturate at all-ones.
REQ-022 All control outputs SHALL be combinational from the state and inputs; the state and counters SHALL be registered.

Reset
REQ-023 Asserting reset SHALL immediately force state=INIT, both counters=0, wait counter=0 and timeout_err=0, so the outputs show INIT values.
REQ-024 Reset asserted mid-MEM_WAIT SHALL abandon the wait; after deassertion there SHALL be exactly one INIT cycle, then RUN.

Structure
REQ-025 State encodings and the flush/write bundle ordering SHALL live in a shared package used by the pipeline-register modules.
REQ-026 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice; the FSM SHALL be inline.

Verification
REQ-027 Release reset -> one cycle with all flushes=1 and pc_write=0, state_o=0, then state_o=1 with pc_write=1.
REQ-028 idex_memtoreg=1, idex_rd=5, id_rs2=5 -> one cycle with pc_write=0 and idex_flush=1, stall_count=1; idex_rd=0 -> no stall.
REQ-029 exmem_branch=1, exmem_zero=1 -> pc_src=1 and ifid/idex/exmem flush=1 for one cycle, flush_count=1.
REQ-030 exmem_memtoreg=1, dmem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with memwb_flush=1 and state_o=2, release on the ready cycle, stall_count=3.
REQ-031 Store with dmem_ready held 0 and MEM_TIMEOUT=4 -> timeout_err=1 after 4 MEM_WAIT cycles, then state RUN; timeout_err stays 1 until reset.
REQ-032 mem_stall, taken and lu together -> freeze only, with pc_src=0; drive CNT_W=2 with repeated stalls -> stall_count stays at 3.
